// File: rtl/light_mode_controller_if.sv
// light_mode_controller_if: button events, sensor inputs and lamp/mode outputs of the light controller.
interface light_mode_controller_if;
  logic A;
  logic B;
  logic presence;
  logic dark;
  logic lamp;
  logic auto_mode;
  modport master (output A, B, presence, dark, input lamp, auto_mode);
  modport slave (input A, B, presence, dark, output lamp, auto_mode);
endinterface

// File: rtl/light_mode_controller.sv
// light_mode_controller: manual/auto lamp mode FSM with sensor synchronizers and hold/timeout counter.
module light_mode_controller #(
  parameter int AUTO_HOLD_T = 30000,
  parameter int MANUAL_TIMEOUT_T = 60000
) (
  input logic clk,
  input logic rst,
  light_mode_controller_if.slave bus
);
  typedef enum logic [2:0] {MAN_OFF, MAN_ON, AUTO_IDLE, AUTO_ON, AUTO_HOLD} state_t;
  localparam logic [15:0] HOLD_LAST = 16'(AUTO_HOLD_T - 1);
  localparam logic [15:0] MAN_LAST = 16'(MANUAL_TIMEOUT_T - 1);
  state_t state, next;
  logic [15:0] cnt;
  logic [1:0] p_sync, d_sync;
  logic ps, ds, lamp_q, auto_q;
  assign ps = p_sync[1];
  assign ds = d_sync[1];
  assign bus.lamp = lamp_q;
  assign bus.auto_mode = auto_q;
  always_comb begin
    next = state;
    if (bus.A)
      next = (state == MAN_OFF || state == MAN_ON) ? AUTO_IDLE : MAN_OFF;
    else
      case (state)
        MAN_OFF: next = bus.B ? MAN_ON : MAN_OFF;
        MAN_ON: next = (bus.B || cnt == MAN_LAST) ? MAN_OFF : MAN_ON;
        AUTO_IDLE: next = (ps && ds) ? AUTO_ON : AUTO_IDLE;
        AUTO_ON: next = !ds ? AUTO_IDLE : !ps ? AUTO_HOLD : AUTO_ON;
        AUTO_HOLD: next = !ds ? AUTO_IDLE : ps ? AUTO_ON : (cnt == HOLD_LAST) ? AUTO_IDLE : AUTO_HOLD;
        default: next = MAN_OFF;
      endcase
  end
  // Outputs are decoded from the next state so they move on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MAN_OFF;
      cnt <= '0;
      p_sync <= '0;
      d_sync <= '0;
      lamp_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      state <= next;
      cnt <= (next != state) ? 16'd0 : cnt + 16'd1;
      p_sync <= {p_sync[0], bus.presence};
      d_sync <= {d_sync[0], bus.dark};
      lamp_q <= next inside {MAN_ON, AUTO_ON, AUTO_HOLD};
      auto_q <= next inside {AUTO_IDLE, AUTO_ON, AUTO_HOLD};
    end
  end
endmodule
